// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Provides the access-size encodings, the responder FSM state type, the data/lane
// width constants, and the access error check used by the top level.
package dmem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Returns 1 for misaligned, out-of-range or illegal-size accesses.
  function automatic logic access_err(input logic [1:0]  size,
                                      input logic [31:0] addr,
                                      input int unsigned depth_words);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr[0];
      SZ_WORD: bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    if ({2'b00, addr[31:2]} >= depth_words) begin
      bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load data alignment: selects the addressed byte or half-word lane from a memory word
// and sign- or zero-extends it to 32 bits. Word loads pass through unchanged.
// Ports:
//   word    - full 32-bit memory word
//   addr_lo - byte address bits [1:0]
//   size    - access size (byte/half/word)
//   uns     - zero-extend when set, sign-extend when clear (byte/half only)
//   result  - extended load data
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              uns,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    result = word;
    case (size)
      SZ_BYTE: result = {{24{byte_sel[7] & ~uns}}, byte_sel};
      SZ_HALF: result = {{16{half_sel[15] & ~uns}}, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's MEM stage. Accepts one load/store at a time on a
// valid/ready request channel, waits WAIT_CYCLES cycles, performs a byte/half/word access
// on an internal word array and returns data or an error on a valid/ready response channel.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   req_valid/req_ready      - request handshake
//   req_we, req_size         - store enable, access size
//   req_unsigned             - zero-extend loads when set
//   req_addr, req_wdata      - byte address, right-aligned store data
//   rsp_valid/rsp_ready      - response handshake
//   rsp_rdata, rsp_err       - extended load data (0 for stores/errors), error flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              latch_en;

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Fields of the access performed this cycle. With zero wait states the access happens
  // on the accept edge itself, so the live request inputs are used instead of the latch.
  logic              acc_we;
  logic [1:0]        acc_size;
  logic              acc_uns;
  logic [31:0]       acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              access;
  logic              acc_err;
  logic [AW-1:0]     acc_idx;
  logic [LANES-1:0]  be;
  logic [DATA_W-1:0] wword;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] load_res;

  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = req_we;
      acc_size  = req_size;
      acc_uns   = req_unsigned;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_q;
      acc_size  = size_q;
      acc_uns   = uns_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  assign access = ((state_q == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                  ((state_q == WAIT) && (cnt_q == 4'd0));

  assign acc_err = access_err(acc_size, acc_addr, DEPTH_WORDS);
  assign acc_idx = acc_addr[2 +: AW];

  // Byte enables and lane-replicated write data.
  always_comb begin
    be    = 4'b0000;
    wword = acc_wdata;
    case (acc_size)
      SZ_BYTE: begin
        be    = 4'b0001 << acc_addr[1:0];
        wword = {4{acc_wdata[7:0]}};
      end
      SZ_HALF: begin
        be    = acc_addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{acc_wdata[15:0]}};
      end
      SZ_WORD: begin
        be    = 4'b1111;
        wword = acc_wdata;
      end
      default: begin
        be    = 4'b0000;
        wword = acc_wdata;
      end
    endcase
  end

  assign rd_word = mem[acc_idx];

  dmem_load_align u_load_align (
    .word    (rd_word),
    .addr_lo (acc_addr[1:0]),
    .size    (acc_size),
    .uns     (acc_uns),
    .result  (load_res)
  );

  // The array is never cleared; writes are blocked while reset is held so a store that
  // was pending when reset arrived is never committed.
  always_ff @(posedge clk) begin
    if (rst && access && acc_we && !acc_err) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) begin
          mem[acc_idx][8*i +: 8] <= wword[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    latch_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          latch_en = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (access) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_we) ? '0 : load_res;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (latch_en) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with DEPTH_WORDS=256, WAIT_CYCLES=2.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  dmem_responder #(
    .DEPTH_WORDS (256),
    .WAIT_CYCLES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction: drives the request, measures cycles from the request cycle to
  // rsp_valid, optionally holds rsp_ready low for 'hold' cycles (with a junk store
  // presented on the request channel), then completes the handshake.
  task automatic xact(input string tag, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    int lat;
    logic [31:0] rd0;
    logic er0;
    @(negedge clk);
    check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    rsp_ready    = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!rsp_valid) begin
      check({tag, "_timeout"}, {31'b0, rsp_valid}, 32'd1);
      return;
    end
    check({tag, "_lat"}, lat, 32'd3);
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    rd0 = rsp_rdata;
    er0 = rsp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'd2;
      req_addr  = 32'h60;
      req_wdata = 32'hFFFFFFFF;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'b0, rsp_valid}, 32'd1);
      check({tag, "_hold_rdata"}, rsp_rdata, rd0);
      check({tag, "_hold_err"}, {31'b0, rsp_err}, {31'b0, er0});
      check({tag, "_hold_req_ready"}, {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_done_valid"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, "_done_ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, "_done_rdata"}, rsp_rdata, 32'd0);
  endtask

  initial begin
    rst          = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    rsp_ready    = 1'b0;
    #12;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Word store/load
    xact("sw10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    xact("lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);

    // Byte store and loads
    xact("sw20", 1'b1, 2'd2, 1'b0, 32'h20, 32'h00000000, 32'h0, 1'b0, 0);
    xact("sb23", 1'b1, 2'd0, 1'b0, 32'h23, 32'h123456A5, 32'h0, 1'b0, 0);
    xact("lb23", 1'b0, 2'd0, 1'b0, 32'h23, 32'h0, 32'hFFFFFFA5, 1'b0, 0);
    xact("lbu23", 1'b0, 2'd0, 1'b1, 32'h23, 32'h0, 32'h000000A5, 1'b0, 0);
    xact("lw20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'hA5000000, 1'b0, 0);

    // Half store and loads
    xact("sw30", 1'b1, 2'd2, 1'b0, 32'h30, 32'h00000000, 32'h0, 1'b0, 0);
    xact("sh32", 1'b1, 2'd1, 1'b0, 32'h32, 32'hFFFF8001, 32'h0, 1'b0, 0);
    xact("lh32", 1'b0, 2'd1, 1'b0, 32'h32, 32'h0, 32'hFFFF8001, 1'b0, 0);
    xact("lhu32", 1'b0, 2'd1, 1'b1, 32'h32, 32'h0, 32'h00008001, 1'b0, 0);
    xact("lw30", 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 32'h80010000, 1'b0, 0);

    // Errors
    xact("sw12_mis", 1'b1, 2'd2, 1'b0, 32'h12, 32'h12345678, 32'h0, 1'b1, 0);
    xact("lw10_keep", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    xact("lw400_oor", 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 0);
    xact("lh21_mis", 1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 32'h0, 1'b1, 0);
    xact("sz3", 1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 0);
    xact("sw3fc", 1'b1, 2'd2, 1'b0, 32'h3FC, 32'h0BADF00D, 32'h0, 1'b0, 0);
    xact("lw3fc", 1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 32'h0BADF00D, 1'b0, 0);

    // Backpressure; a store to 0x60 presented meanwhile must be ignored
    xact("sw60", 1'b1, 2'd2, 1'b0, 32'h60, 32'h5555AAAA, 32'h0, 1'b0, 0);
    xact("lw10_bp", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 4);
    xact("lw60", 1'b0, 2'd2, 1'b0, 32'h60, 32'h0, 32'h5555AAAA, 1'b0, 0);

    // Reset during WAIT drops a pending store
    xact("sw40", 1'b1, 2'd2, 1'b0, 32'h40, 32'h11111111, 32'h0, 1'b0, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd2;
    req_addr  = 32'h40;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_req_ready", {31'b0, req_ready}, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    check("mid_rst_rdata", rsp_rdata, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    xact("lw40", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h11111111, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined core's MEM stage; it is the target side of the core's load/store request interface.
- Accepts one load or store at a time over a valid/ready request channel.
- Inserts a configurable number of wait states, performs a byte/half/word access on an internal word array, and returns data or an error over a valid/ready response channel.
- Used in `main_top` in place of an ideal single-cycle memory so that pipeline stall paths are exercised.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 2, wait states between request accept and response; range 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_unsigned  in  1  loads only: zero-extend when set, sign-extend when clear.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  misaligned address, out-of-range address, or illegal size.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - The memory array is not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/size/unsigned/addr/wdata.
  - If WAIT_CYCLES=0, go to RESP; otherwise load the counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; at 0, go to RESP.
- Access: performed on the clock edge that enters RESP. The store write and the load data capture both happen on that edge.
- Latency: request accept edge to rsp_valid high = WAIT_CYCLES+1 cycles.
- RESP:
  - rsp_valid=1 and req_ready=0.
  - rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready.
  - On that handshake, go to IDLE and clear rsp_valid, rsp_rdata and rsp_err. The next request can be accepted in the following cycle; there is no back-to-back overlap.
- Error detection:
  - size=1 with addr[0]=1 is an error.
  - size=2 with addr[1:0]!=0 is an error.
  - size=3 is an error.
  - addr[31:2] >= DEPTH_WORDS is an error.
  - On error: no write, rsp_rdata=0, rsp_err=1; latency is unchanged.
- Stores:
  - Byte: write byte lane addr[1:0] with wdata[7:0].
  - Half: write lanes {addr[1],0}+1 and {addr[1],0} with wdata[15:0].
  - Word: write all four lanes.
  - Other lanes of the word are unchanged (byte-enable write).
- Loads: select lane(s) by addr[1:0], then sign- or zero-extend to 32 bits per req_unsigned. req_unsigned is ignored for word loads.
- req_* inputs are ignored whenever req_ready=0.
- rsp_ready is ignored whenever rsp_valid=0.
- Reset asserted mid-WAIT or mid-RESP:
  - The pending transaction is dropped and outputs return to reset values immediately.
  - A pending store has not yet been written and must not be written.

Decomposition:
- Package dmem_pkg:
  - Size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2.
  - FSM state enum: IDLE, WAIT, RESP.
  - Width localparams: 32-bit data, 4 byte lanes.
- Sub-module dmem_load_align: combinational lane select plus sign/zero extension. Inputs are word, addr[1:0], size and unsigned; output is the 32-bit result.
- Top-level contents: FSM, counter, array, byte-enable generation and error check.

Test Plan:
1. WAIT_CYCLES=2:
   - SW 0xDEADBEEF @0x10, then LW @0x10 → rsp_valid 3 cycles after each accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
2. Byte store and loads:
   - SW 0x00000000 @0x20, then SB 0xA5 @0x23.
   - LB @0x23 → 0xFFFFFFA5; LBU @0x23 → 0x000000A5; LW @0x20 → 0xA5000000.
3. Half store and loads:
   - SH 0x8001 @0x32, then LH @0x32 → 0xFFFF8001; LHU @0x32 → 0x00008001.
4. Errors:
   - SW 0x12345678 @0x12 (misaligned) → rsp_err=1, rsp_rdata=0; subsequent LW @0x10 returns the prior value unchanged.
   - LW @0x400 with DEPTH_WORDS=256 → rsp_err=1.
5. Response backpressure:
   - Hold rsp_ready=0 for 4 cycles during an LW response → rsp_valid, rsp_rdata and rsp_err stay constant; req_ready=0 throughout.
   - Raising rsp_ready returns the FSM to IDLE next cycle, with req_ready=1.
6. Reset mid-operation:
   - Issue SW 0xCAFEF00D @0x40 and drop rst during WAIT → rsp_valid=0 and req_ready=1 immediately.
   - After release, LW @0x40 returns the pre-existing word, not 0xCAFEF00D.
